neuron_layer_ctrl: RTL and testbench
====================================

# neuron_layer_ctrl

Sequencer for one fully-connected neural-network layer built from the 8-bit input/output registers and the 21-bit accumulator register. It walks the neurons of the layer one at a time. For each neuron it clears the accumulator, streams N_IN input/weight pairs through the MAC, then loads the activated result into the 8-bit output register and offers it downstream on a valid/ready handshake. It sits between the top-level network controller (start/done) and the layer datapath plus its input and weight memories.

## Interface
- N_IN, 8, inputs per neuron; must be ≥ 2.
- N_OUT, 4, neurons per layer; must be ≥ 2.
- IW, $clog2(N_IN), input index width.
- NW, $clog2(N_OUT), neuron index width.
- WAW, $clog2(N_IN*N_OUT), weight address width.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a layer pass; sampled only in IDLE.
- abort  in  1  cancel the current pass.
- in_idx  out  IW  input memory address.
- w_addr  out  WAW  weight memory address, equal to neu_idx*N_IN + in_idx.
- neu_idx  out  NW  index of the current neuron.
- in_ld  out  1  load enable for the input/weight 8-bit registers.
- acc_clr  out  1  clear for the 21-bit accumulator.
- acc_ld  out  1  load enable for the accumulator.
- out_ld  out  1  load enable for the output 8-bit register.
- out_valid  out  1  the output register holds the result for neu_idx.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle pulse after the last neuron is accepted.

## Operation
States and transitions:
- IDLE: start=1 → CLR, with neu_idx=0.
- CLR: acc_clr=1, in_idx=0 → MAC.
- MAC: in_ld=1; in_idx increments every cycle.
  - acc_ld is in_ld delayed by one cycle, to match the input register stage.
  - Leaves when in_idx==N_IN-1 → DRAIN.
- DRAIN: acc_ld=1, which is the final accumulate → WRITE.
- WRITE: out_ld=1 → OUT.
- OUT: out_valid=1 until out_ready=1. On the accept cycle:
  - If neu_idx==N_OUT-1 → DONE.
  - Otherwise neu_idx+1 → CLR.
- DONE: done=1 for one cycle → IDLE.

Enables:
- in_ld is asserted only in MAC.
- acc_ld is asserted only in the MAC cycles after the first, and in DRAIN.
- Exactly N_IN acc_ld pulses occur per neuron.

Counters:
- in_idx and neu_idx never wrap mid-pass.
- Both are 0 in IDLE and DONE.

Precedence rules:
- start while busy is ignored.
- abort in any non-IDLE state → IDLE next cycle. acc_clr=1 in the abort cycle. done is not pulsed.
- abort has priority over an out_ready accept in the same cycle.
- rst low has priority over everything.

Reset: every output is 0 and the state is IDLE.

The controller does no arithmetic. Width safety of the 21-bit accumulator (N_IN ≤ 32 for signed 8×8 products) is the datapath's concern; it is checked by assertion in the bench.

## Timing
- Start to first in_ld: 2 cycles (IDLE→CLR→MAC).
- Per neuron, with out_ready held high: N_IN + 4 cycles (CLR, N_IN × MAC, DRAIN, WRITE, OUT).
- Full pass: N_OUT*(N_IN+4) + 1 cycles from the cycle after start to done, inclusive of DONE.
- out_valid rises the cycle after out_ld. The result is stable while out_valid=1.
- Back-to-back: start may be asserted in the cycle after done, while the block is in IDLE.
- All outputs are registered or decoded from the state only. No combinational path from out_ready to any output except the next-state logic.

## Structure
- Shared package nn_pkg holds:
  - the state encoding localparams (IDLE, CLR, MAC, DRAIN, WRITE, OUT, DONE; 3-bit);
  - DW=8 and AW=21 datapath widths.
- Sub-module idx_counter is instantiated twice, for in_idx and neu_idx.
  - Parameterised modulus; ports clr, inc, count, last.
- The top module holds the FSM, the acc_ld delay flop and the w_addr computation.

## Test plan
Defaults: N_IN=4 and N_OUT=3 unless stated.
- Reset: rst=0 for 2 cycles during MAC → all outputs 0 and state IDLE the next cycle. done never pulses.
- Nominal pass, out_ready tied 1, start pulse → done exactly 25 cycles later. w_addr sequence is 0..11. acc_ld count is 12 and acc_clr count is 3.
- Backpressure: out_ready=0 for 5 cycles at neuron 1 → out_valid held and neu_idx stays 1. No in_ld in that window. Total pass is 30 cycles.
- Abort in MAC at in_idx=2 of neuron 2 → acc_clr=1 in that cycle and IDLE next. busy=0, no done. The next start restarts at neu_idx=0.
- start held high through a whole pass → exactly one pass per IDLE entry. A new pass begins the cycle after done.
- N_IN=2, N_OUT=2 → per-neuron latency 6 cycles. in_idx toggles 0,1 and w_addr is 0,1,2,3.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and widths for the fully-connected layer sequencer and its datapath.
package nn_pkg;

  localparam int DW = 8;
  localparam int AW = 21;

  // Largest fan-in whose signed 8x8 products are guaranteed to fit the accumulator.
  localparam int MAX_N_IN = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idx_counter.sv
// Modulo-MOD index counter with synchronous clear; clear wins over increment.
module idx_counter
  import nn_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = idx_width(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(MOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully-connected layer: clear, N_IN MACs, drain, write, then
// hand each neuron's result downstream on a valid/ready handshake.
module neuron_layer_ctrl
  import nn_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int IW    = $clog2(N_IN),
  parameter int NW    = $clog2(N_OUT),
  parameter int WAW   = $clog2(N_IN * N_OUT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic [IW-1:0]  in_idx,
  output logic [WAW-1:0] w_addr,
  output logic [NW-1:0]  neu_idx,
  output logic           in_ld,
  output logic           acc_clr,
  output logic           acc_ld,
  output logic           out_ld,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  state_t state;
  state_t nxt;
  logic   abort_hit;
  logic   acc_clr_q;
  logic   in_last;
  logic   neu_last;
  logic   in_clr;
  logic   in_inc;
  logic   neu_clr;
  logic   neu_inc;

  // Abort clears the accumulator in the very cycle it is seen, not one later.
  assign abort_hit = rst && abort && (state != S_IDLE);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    nxt = state;
    if (abort_hit) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  nxt = start ? S_CLR : S_IDLE;
        S_CLR:   nxt = S_MAC;
        S_MAC:   nxt = in_last ? S_DRAIN : S_MAC;
        S_DRAIN: nxt = S_WRITE;
        S_WRITE: nxt = S_OUT;
        S_OUT:   nxt = out_ready ? (neu_last ? S_DONE : S_CLR) : S_OUT;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign in_inc  = (state == S_MAC) && (nxt == S_MAC);
  assign in_clr  = !in_inc;
  assign neu_inc = (state == S_OUT) && (nxt == S_CLR);
  assign neu_clr = (nxt == S_IDLE) || (nxt == S_DONE);

  idx_counter #(.MOD(N_IN), .W(IW)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_clr),
    .inc   (in_inc),
    .count (in_idx),
    .last  (in_last)
  );

  idx_counter #(.MOD(N_OUT), .W(NW)) u_neu_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (neu_clr),
    .inc   (neu_inc),
    .count (neu_idx),
    .last  (neu_last)
  );

  assign w_addr  = WAW'(neu_idx) * WAW'(N_IN) + WAW'(in_idx);
  assign acc_clr = acc_clr_q || abort_hit;

  // Outputs register the decode of the next state, so they change together with state.
  // acc_ld is in_ld one cycle later, dropped if the pass is being abandoned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ld     <= 1'b0;
      acc_ld    <= 1'b0;
      acc_clr_q <= 1'b0;
      out_ld    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt;
      in_ld     <= (nxt == S_MAC);
      acc_ld    <= in_ld && (nxt != S_IDLE);
      acc_clr_q <= (nxt == S_CLR);
      out_ld    <= (nxt == S_WRITE);
      out_valid <= (nxt == S_OUT);
      busy      <= (nxt != S_IDLE);
      done      <= (nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench for neuron_layer_ctrl: table-driven opening of a pass, then
// hand-written sequences for backpressure, abort, held start, reset and a 2x2 layer.
module tb_neuron_layer_ctrl;
  import nn_pkg::*;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int IW    = $clog2(N_IN);
  localparam int NW    = $clog2(N_OUT);
  localparam int WAW   = $clog2(N_IN * N_OUT);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic           out_ready;
  logic [IW-1:0]  in_idx;
  logic [WAW-1:0] w_addr;
  logic [NW-1:0]  neu_idx;
  logic           in_ld, acc_clr, acc_ld, out_ld, out_valid, busy, done;

  logic           start2;
  logic [0:0]     s_in_idx;
  logic [1:0]     s_w_addr;
  logic [0:0]     s_neu_idx;
  logic           s_in_ld, s_acc_clr, s_acc_ld, s_out_ld, s_out_valid, s_busy, s_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc_ld = 0;
  int n_acc_clr = 0;
  int n_done   = 0;
  int w_log[$];
  int s_w_log[$];
  int s_idx_log[$];

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic [6:0] flags;   // {in_ld, acc_clr, acc_ld, out_ld, out_valid, busy, done}
    int         in_idx;
    int         neu_idx;
    int         w_addr;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  neuron_layer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_idx(in_idx), .w_addr(w_addr), .neu_idx(neu_idx),
    .in_ld(in_ld), .acc_clr(acc_clr), .acc_ld(acc_ld), .out_ld(out_ld),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  neuron_layer_ctrl #(.N_IN(2), .N_OUT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .in_idx(s_in_idx), .w_addr(s_w_addr), .neu_idx(s_neu_idx),
    .in_ld(s_in_ld), .acc_clr(s_acc_clr), .acc_ld(s_acc_ld), .out_ld(s_out_ld),
    .out_valid(s_out_valid), .out_ready(1'b1), .busy(s_busy), .done(s_done)
  );

  always @(posedge clk) begin
    if (acc_ld)  n_acc_ld++;
    if (acc_clr) n_acc_clr++;
    if (done)    n_done++;
    if (in_ld)   w_log.push_back(int'(w_addr));
    if (s_in_ld) begin
      s_w_log.push_back(int'(s_w_addr));
      s_idx_log.push_back(int'(s_in_idx));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, then settle before sampling.
  task automatic cyc(input logic s, input logic a, input logic r);
    @(posedge clk);
    #1;
    start     = s;
    abort     = a;
    out_ready = r;
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {in_ld, acc_clr, acc_ld, out_ld, out_valid, busy, done};
  endfunction

  function automatic logic [6:0] s_flags();
    return {s_in_ld, s_acc_clr, s_acc_ld, s_out_ld, s_out_valid, s_busy, s_done};
  endfunction

  function automatic vec_t mk(input logic s, input logic [6:0] f, input int i, input int n,
                              input int w);
    vec_t v;
    v.start   = s;
    v.abort   = 1'b0;
    v.ready   = 1'b1;
    v.flags   = f;
    v.in_idx  = i;
    v.neu_idx = n;
    v.w_addr  = w;
    return v;
  endfunction

  initial begin
    int done_c;
    int ld0, clr0, wl0, d0, s0;
    int clr_a, clr_b;

    assert (N_IN <= MAX_N_IN);

    // Opening of a nominal pass, cycle 0 is the IDLE cycle that samples start.
    tbl[0]  = mk(1'b1, 7'b0000000, 0, 0, 0);
    tbl[1]  = mk(1'b0, 7'b0100010, 0, 0, 0);
    tbl[2]  = mk(1'b0, 7'b1000010, 0, 0, 0);
    tbl[3]  = mk(1'b0, 7'b1010010, 1, 0, 1);
    tbl[4]  = mk(1'b1, 7'b1010010, 2, 0, 2);
    tbl[5]  = mk(1'b0, 7'b1010010, 3, 0, 3);
    tbl[6]  = mk(1'b0, 7'b0010010, 0, 0, 0);
    tbl[7]  = mk(1'b0, 7'b0001010, 0, 0, 0);
    tbl[8]  = mk(1'b0, 7'b0000110, 0, 0, 0);
    tbl[9]  = mk(1'b0, 7'b0100010, 0, 1, 4);
    tbl[10] = mk(1'b0, 7'b1000010, 0, 1, 4);
    tbl[11] = mk(1'b0, 7'b1010010, 1, 1, 5);

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", flags(), 0);
    check("reset_idx", {in_idx, neu_idx, w_addr}, 0);
    check("reset_flags_small", s_flags(), 0);
    rst = 1'b1;

    // Nominal pass with out_ready tied high.
    ld0 = 0; clr0 = 0; wl0 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].start, tbl[i].abort, tbl[i].ready);
      if (i == 0) begin
        ld0 = n_acc_ld; clr0 = n_acc_clr; wl0 = w_log.size();
      end
      check($sformatf("nom_flags c%0d", i), flags(), tbl[i].flags);
      check($sformatf("nom_in_idx c%0d", i), in_idx, tbl[i].in_idx);
      check($sformatf("nom_neu_idx c%0d", i), neu_idx, tbl[i].neu_idx);
      check($sformatf("nom_w_addr c%0d", i), w_addr, tbl[i].w_addr);
    end
    done_c = -1;
    for (int c = 12; c < 60; c++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (done) begin
        done_c = c;
        break;
      end
    end
    check("nom_done_cycle", done_c, 25);
    check("nom_done_idx", {in_idx, neu_idx}, 0);
    check("nom_acc_ld_count", n_acc_ld - ld0, 12);
    check("nom_acc_clr_count", n_acc_clr - clr0, 3);
    check("nom_w_log_len", w_log.size() - wl0, 12);
    if (w_log.size() >= wl0 + 12)
      for (int k = 0; k < 12; k++) check($sformatf("nom_w_seq %0d", k), w_log[wl0 + k], k);

    // Backpressure: downstream stalls 5 cycles while neuron 1 is offered.
    cyc(1'b1, 1'b0, 1'b1);
    done_c = -1;
    for (int c = 1; c < 60; c++) begin
      cyc(1'b0, 1'b0, (c >= 16 && c <= 20) ? 1'b0 : 1'b1);
      if (c >= 16 && c <= 20) begin
        check($sformatf("bp_valid c%0d", c), out_valid, 1);
        check($sformatf("bp_neu c%0d", c), neu_idx, 1);
        check($sformatf("bp_no_load c%0d", c), {in_ld, out_ld}, 0);
      end
      if (done) begin
        done_c = c;
        break;
      end
    end
    check("bp_done_cycle", done_c, 30);

    // Abort at in_idx 2 of neuron 2.
    cyc(1'b1, 1'b0, 1'b1);
    d0 = n_done;
    for (int c = 1; c <= 20; c++) cyc(1'b0, (c == 20), 1'b1);
    check("abort_acc_clr", acc_clr, 1);
    check("abort_pos", {in_ld, in_idx, neu_idx}, {1'b1, 2'd2, 2'd2});
    cyc(1'b0, 1'b0, 1'b1);
    check("abort_idle_flags", flags(), 0);
    check("abort_idle_neu", neu_idx, 0);
    repeat (8) cyc(1'b0, 1'b0, 1'b1);
    check("abort_no_done", n_done - d0, 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("restart_clr", {acc_clr, busy, neu_idx}, {1'b1, 1'b1, 2'd0});
    cyc(1'b0, 1'b0, 1'b1);
    check("restart_first_mac", {in_ld, w_addr}, {1'b1, 4'd0});
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("restart_abort_idle", busy, 0);

    // start held high: one pass per IDLE entry, next pass right after done.
    d0 = n_done;
    done_c = -1;
    for (int c = 0; c <= 27; c++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (done && done_c < 0) done_c = c;
      if (c == 26) check("held_idle_gap", busy, 0);
    end
    check("held_done_cycle", done_c, 25);
    check("held_done_count", n_done - d0, 1);
    check("held_restart_flags", flags(), 7'b0100010);
    check("held_restart_neu", neu_idx, 0);

    // Reset low for 2 cycles in MAC, with abort raised to test reset priority.
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    d0 = n_done;
    cyc(1'b0, 1'b1, 1'b1);
    check("rst_flags_1", flags(), 0);
    check("rst_idx_1", {in_idx, neu_idx, w_addr}, 0);
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_flags_2", flags(), 0);
    repeat (8) cyc(1'b0, 1'b0, 1'b1);
    check("rst_stays_idle", busy, 0);
    check("rst_no_done", n_done - d0, 0);

    // 2x2 layer: per-neuron latency 6, address walk 0..3.
    s0 = s_w_log.size();
    done_c = -1; clr_a = -1; clr_b = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      start2 = (c == 0);
      #1;
      if (s_acc_clr) begin
        if (clr_a < 0) clr_a = c;
        else if (clr_b < 0) clr_b = c;
      end
      if (s_done) begin
        done_c = c;
        break;
      end
    end
    check("small_clr_first", clr_a, 1);
    check("small_clr_second", clr_b, 7);
    check("small_done_cycle", done_c, 13);
    check("small_log_len", s_w_log.size() - s0, 4);
    if (s_w_log.size() >= s0 + 4)
      for (int k = 0; k < 4; k++) begin
        check($sformatf("small_w_seq %0d", k), s_w_log[s0 + k], k);
        check($sformatf("small_idx_seq %0d", k), s_idx_log[s0 + k], k % 2);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
